// File: rtl/par2serial_tx_if.sv
// Parallel-side link of par2serial_tx: word/valid/enable in, serial bit,
// consume strobe and link status out.
interface par2serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             data_out;
    logic             load_ack;
    logic             active;

    modport master (
        output enable, valid_in, data_in,
        input  data_out, load_ack, active
    );

    modport slave (
        input  enable, valid_in, data_in,
        output data_out, load_ack, active
    );
endinterface

// File: rtl/par2serial_tx.sv
// MSB-first serializer with an IDLE/TRAIN/ACTIVE link FSM; one WIDTH-bit
// word per WIDTH clk_in cycles, decisions taken only at word boundaries.
module par2serial_tx #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COM         = 8'hBC,
    parameter int               TRAIN_WORDS = 4
) (
    input  logic           clk_in,
    input  logic           reset,
    par2serial_tx_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TRN_W = (TRAIN_WORDS > 0) ? $clog2(TRAIN_WORDS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TRN_W-1:0] train_cnt_q, train_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             data_out_q, data_out_d;
    logic             load_ack_q, load_ack_d;
    logic             active_q, active_d;
    logic [WIDTH-1:0] word;
    logic             boundary;

    always_comb begin
        boundary    = (bit_cnt_q == '0);
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        word        = '0;
        load_ack_d  = 1'b0;
        data_out_d  = shift_q[WIDTH-1];
        shift_d     = {shift_q[WIDTH-2:0], 1'b0};

        if (boundary) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_d     = ST_TRAIN;
                        train_cnt_d = '0;
                    end
                end
                ST_TRAIN: begin
                    if (!bus.enable)
                        state_d = ST_IDLE;
                    else if (train_cnt_q == TRN_W'(TRAIN_WORDS))
                        state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!bus.enable)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            // Word is chosen for the state being entered, so a disable wins over valid_in.
            case (state_d)
                ST_TRAIN: begin
                    word        = COM;
                    train_cnt_d = train_cnt_d + TRN_W'(1);
                end
                ST_ACTIVE: begin
                    if (bus.valid_in) begin
                        word       = bus.data_in;
                        load_ack_d = 1'b1;
                    end else begin
                        word = COM;
                    end
                end
                default: word = '0;
            endcase

            data_out_d = word[WIDTH-1];
            shift_d    = {word[WIDTH-2:0], 1'b0};
        end

        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            train_cnt_q <= '0;
            shift_q     <= '0;
            data_out_q  <= 1'b0;
            load_ack_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            train_cnt_q <= train_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            load_ack_q  <= load_ack_d;
            active_q    <= active_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.load_ack = load_ack_q;
    assign bus.active   = active_q;
endmodule

// File: tb/tb_par2serial_tx.sv
// Bench for par2serial_tx: word-level vector table, hand-built corner
// sequences and a randomized run against a word-level reference model.
module tb_par2serial_tx;
    localparam int         WIDTH = 8;
    localparam logic [7:0] COM   = 8'hBC;
    localparam int         TW    = 4;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic reset1 = 1'b1;

    par2serial_tx_if #(.WIDTH(WIDTH)) bus  ();
    par2serial_tx_if #(.WIDTH(WIDTH)) bus1 ();

    par2serial_tx #(.WIDTH(WIDTH), .COM(COM), .TRAIN_WORDS(TW)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    par2serial_tx #(.WIDTH(WIDTH), .COM(COM), .TRAIN_WORDS(1)) dut1 (
        .clk_in (clk_in),
        .reset  (reset1),
        .bus    (bus1)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic en, input logic val, input logic [7:0] d);
        bus.enable   = en;
        bus.valid_in = val;
        bus.data_in  = d;
    endtask

    // Assert reset between edges, hold 3 edges, release between edges so the next edge is a boundary.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_outs", {29'd0, bus.data_out, bus.load_ack, bus.active}, 32'd0);
        repeat (3) cycle();
        reset = 1'b0;
    endtask

    // Run one full word starting just before a boundary edge.
    task automatic send_word(input logic en, input logic val, input logic [7:0] d,
                             output logic [7:0] got, output int acks,
                             output logic ack_first, output logic act_first);
        drive(en, val, d);
        got = '0; acks = 0; ack_first = 1'b0; act_first = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cycle();
            got = {got[6:0], bus.data_out};
            acks += int'(bus.load_ack);
            if (i == 0) begin
                ack_first = bus.load_ack;
                act_first = bus.active;
            end
        end
    endtask

    typedef struct {
        logic       en;
        logic       val;
        logic [7:0] din;
        logic [7:0] exp_word;
        logic       exp_ack;
        logic       exp_act;
    } vec_t;

    vec_t vecs[14];

    // Word-level reference model: link state and the word on the wire.
    int         m_state;   // 0 idle, 1 train, 2 active
    int         m_train;
    int         m_pos;
    logic [7:0] m_word;
    logic       e_dout, e_ack, e_act;

    task automatic model_reset();
        m_state = 0; m_train = 0; m_pos = 0; m_word = '0;
    endtask

    task automatic model_edge(input logic en, input logic val, input logic [7:0] d);
        e_ack = 1'b0;
        if (m_pos == 0) begin
            if (!en)                            m_state = 0;
            else if (m_state == 0)              begin m_state = 1; m_train = 0; end
            else if (m_state == 1 && m_train == TW) m_state = 2;
            if (m_state == 0)      m_word = 8'h00;
            else if (m_state == 1) begin m_word = COM; m_train = m_train + 1; end
            else if (val)          begin m_word = d; e_ack = 1'b1; end
            else                   m_word = COM;
        end
        e_dout = m_word[WIDTH-1-m_pos];
        e_act  = (m_state == 2);
        m_pos  = (m_pos + 1) % WIDTH;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        int         acks;
        logic       ackf, actf;

        drive(1'b0, 1'b0, 8'h00);
        bus1.enable = 1'b0; bus1.valid_in = 1'b0; bus1.data_in = 8'h00;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, COM,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h11, COM,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h22, COM,   1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h33, COM,   1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h44, COM,   1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'h99, COM,   1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'h77, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h66, COM,   1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 8'h55, COM,   1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 8'h44, COM,   1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 8'h33, COM,   1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b1};

        // Reset and idle
        do_reset();
        for (int c = 0; c < 40; c++) begin
            cycle();
            check("idle_outs", {29'd0, bus.data_out, bus.load_ack, bus.active}, 32'd0);
        end

        // Training, data, disable priority, retrain
        do_reset();
        for (int v = 0; v < 14; v++) begin
            send_word(vecs[v].en, vecs[v].val, vecs[v].din, got, acks, ackf, actf);
            check($sformatf("vec%0d_word", v), {24'd0, got}, {24'd0, vecs[v].exp_word});
            check($sformatf("vec%0d_ack", v), {acks[29:0], ackf, actf},
                  {29'd0, vecs[v].exp_ack, vecs[v].exp_ack, vecs[v].exp_act});
        end

        // Disable mid-word: the word in flight completes, then a zero word with no ack
        drive(1'b1, 1'b1, 8'hFF);
        got = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cycle();
            got = {got[6:0], bus.data_out};
            if (i == 2) drive(1'b0, 1'b1, 8'h00);
        end
        check("dis_inflight", {24'd0, got}, 32'h0000_00FF);
        send_word(1'b0, 1'b1, 8'hFF, got, acks, ackf, actf);
        check("dis_zero_word", {24'd0, got}, 32'd0);
        check("dis_ack_act", {acks[30:0], actf}, 32'd0);

        // Asynchronous reset in the middle of an A5 data word
        for (int w = 0; w < 5; w++) send_word(1'b1, 1'b0, 8'h00, got, acks, ackf, actf);
        drive(1'b1, 1'b1, 8'hA5);
        repeat (6) cycle();
        check("pre_rst_outs", {30'd0, bus.data_out, bus.active}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_outs", {29'd0, bus.data_out, bus.load_ack, bus.active}, 32'd0);
        repeat (2) cycle();
        reset = 1'b0;
        for (int w = 0; w < 5; w++) begin
            send_word(1'b1, 1'b0, 8'h00, got, acks, ackf, actf);
            check($sformatf("retrain%0d_word", w), {24'd0, got}, {24'd0, COM});
            check($sformatf("retrain%0d_act", w), {acks[30:0], actf}, {31'd0, (w == 4)});
        end

        // TRAIN_WORDS=1 instance: one COM word then data
        repeat (2) cycle();
        reset1 = 1'b0;
        for (int w = 0; w < 2; w++) begin
            bus1.enable   = 1'b1;
            bus1.valid_in = (w == 1);
            bus1.data_in  = 8'hC3;
            got = '0; acks = 0; actf = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cycle();
                got = {got[6:0], bus1.data_out};
                acks += int'(bus1.load_ack);
                if (i == 0) actf = bus1.active;
            end
            check($sformatf("tw1_word%0d", w), {24'd0, got}, (w == 0) ? {24'd0, COM} : 32'h0000_00C3);
            check($sformatf("tw1_ack_act%0d", w), {acks[30:0], actf}, (w == 0) ? 32'd0 : 32'd3);
        end

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic       en, val;
            logic [7:0] d;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check("rand_rst", {29'd0, bus.data_out, bus.load_ack, bus.active}, 32'd0);
                cycle();
                reset = 1'b0;
            end else begin
                en  = ($urandom_range(0, 15) != 0);
                val = $urandom_range(0, 1) == 1;
                d   = 8'($urandom);
                drive(en, val, d);
                model_edge(en, val, d);
                cycle();
                check($sformatf("rand_c%0d", c), {29'd0, bus.data_out, bus.load_ack, bus.active},
                      {29'd0, e_dout, e_ack, e_act});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/par2serial_tx.md
# par2serial_tx

Serial transmit stage clocked directly by the fast `clk_in` that feeds the clock divider tree. It serializes one WIDTH-bit word every WIDTH cycles of `clk_in`, MSB first. A small link state machine sends zero-idle, then a fixed burst of COM symbols, then user data or COM fill. Upstream logic runs on the divided word-rate clock (`clk_f`) and sees a one-cycle `load_ack` strobe each time a data word is taken.

## Interface
- `WIDTH`, 8: word width in bits; must be a power of two.
- `COM`, 8'hBC: comma/fill symbol.
- `TRAIN_WORDS`, 4: number of COM words sent in TRAIN before ACTIVE (≥1).
- `clk_in`  input  1  single clock, all flops rising-edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `enable`  input  1  link enable, sampled only at word boundaries.
- `data_in`  input  WIDTH  parallel data word.
- `valid_in`  input  1  `data_in` is valid; sampled only at word boundaries.
- `data_out`  output  1  registered serial bit.
- `load_ack`  output  1  registered one-cycle pulse: a data word was consumed.
- `active`  output  1  registered; high while state is ACTIVE.

## Operation
- **Bit counter `bit_cnt`**: log2(WIDTH) bits; increments every cycle and wraps WIDTH-1→0. A *boundary* is any edge at which `bit_cnt`==0. The first edge after reset release is a boundary.
- **States**: IDLE, TRAIN, ACTIVE. Reset enters IDLE. Transitions occur only at boundaries:
  - IDLE→TRAIN if `enable`=1; the train counter is cleared to 0.
  - TRAIN→IDLE if `enable`=0.
  - TRAIN→ACTIVE if `enable`=1 and the train counter == TRAIN_WORDS.
  - Otherwise TRAIN stays in TRAIN.
  - ACTIVE→IDLE if `enable`=0.
- **Word selection at a boundary**: the next state is evaluated first, then the word is chosen for that next state:
  - IDLE: all zeros.
  - TRAIN: COM, and the train counter increments.
  - ACTIVE with `valid_in`=1: `data_in`.
  - ACTIVE with `valid_in`=0: COM.
- **Boundary edge**:
  - `data_out` <= W[WIDTH-1].
  - shift <= {W[WIDTH-2:0], 0}.
- **Non-boundary edge**:
  - `data_out` <= shift[WIDTH-1].
  - shift <= shift << 1.
- **`load_ack`**: set to 1 for exactly the cycle after a boundary where `data_in` was taken; 0 otherwise.
- **`active`**: equals (next state == ACTIVE), registered at every edge. Between boundaries it holds its value.
- `enable` and `valid_in` are don't-care between boundaries. A mid-word change never corrupts the word in flight.
- **Reset mid-word**: the word in flight is truncated. All registers clear, and serialization restarts from a boundary on the first edge after release.

## Timing
- **Reset values**:
  - `data_out`=0, `load_ack`=0, `active`=0.
  - `bit_cnt`=0, shift=0, train counter=0, state=IDLE.
- **Latency**: a word taken at boundary edge E has its MSB on `data_out` after E and its LSB after E+WIDTH-1. `load_ack` is high during cycle E..E+1.
- **Throughput**: 1 word per WIDTH cycles, i.e. one per `clk_f` period when WIDTH=8 and `clk_f`=`clk_in`/8. There are no gaps or bubbles between words.
- **Training**: with `enable` held high from reset release, the first boundary (edge 0) loads COM. TRAIN_WORDS COMs go out on edges 0, 8, …, 8·(TRAIN_WORDS-1). The boundary at edge 8·TRAIN_WORDS enters ACTIVE and samples the first data word.
- **Bit order**: COM=8'hBC serializes as 1,0,1,1,1,1,0,0.
- **Simultaneous events at one boundary**: `enable`=0 has priority over `valid_in`. With `enable`=0 the zero word is sent, there is no `load_ack`, and the data word is not consumed.

## Test plan
- **Reset and idle**: reset high for 3 cycles, then `enable`=0 for 40 cycles → `data_out`=0, `active`=0 and `load_ack`=0 throughout; `bit_cnt` wraps every 8 cycles.
- **Training**: `enable`=1 and `valid_in`=0 from reset release → 4 repetitions of 10111100 on `data_out` (cycles 1–32). `active` rises after edge 32. COM fill continues after that with no `load_ack`.
- **Data**: in ACTIVE, present `data_in`=8'hA5 with `valid_in`=1 at one boundary, then 8'h3C at the next → bit stream 10100101 then 00111100 back-to-back. Exactly two `load_ack` pulses, 8 cycles apart.
- **Disable mid-word**: drop `enable` at bit 3 of 8'hFF → all 8 ones complete. The next word is 00000000, `active` falls at that boundary, and `valid_in`=1 produces no `load_ack`.
- **Asynchronous reset mid-word**: assert `reset` between edges during bit 5 of 8'hA5 → `data_out`, `active` and `load_ack` read 0 immediately. After release, a new 4-word training sequence starts.
- **Retrain**: cycle `enable` 1→0→1 → IDLE zero word, then 4 fresh COM words before ACTIVE returns. `TRAIN_WORDS`=1 variant → only one COM word before data.
